taxi_axil_regfile: RTL and testbench
====================================

TAXI_AXIL_REGFILE -- requirements
Module: taxi_axil_regfile

Interface
REQ-001 SHALL have parameter REG_CNT, default 16: number of DATA_W-bit registers, power of two, 2..256.
REQ-002 SHALL have parameter RESET_VAL, default 0: value loaded into every register on reset.
REQ-003 SHALL derive DATA_W, ADDR_W and STRB_W from the attached taxi_axil_if. DATA_W is 32 or 64, and STRB_W = DATA_W/8.
REQ-004 SHALL have port: clk  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port: s_axil_wr  taxi_axil_if.wr_slv  bundle  AXI4-lite write responder (AW, W, B).
REQ-007 SHALL have port: s_axil_rd  taxi_axil_if.rd_slv  bundle  AXI4-lite read responder (AR, R).
REQ-008 SHALL have port: reg_out  output  REG_CNT*DATA_W  current register contents; register i at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port: wr_pulse  output  REG_CNT  one-cycle strobe; bit i high the cycle after register i is written.
REQ-010 SHALL have port: rd_pulse  output  REG_CNT  one-cycle strobe; bit i high the cycle a read of register i is accepted.

Function
REQ-011 Register index: addr[log2(STRB_W) +: log2(REG_CNT)]. Low byte-offset bits ignored.
REQ-012 Address in range: addr >> log2(STRB_W) < REG_CNT. Higher address bits nonzero means out of range.
REQ-013 Write path states: IDLE and RESP.
REQ-014 IDLE: awready and wready both high only when awvalid && wvalid, so both are accepted in the same cycle. Either valid alone is not accepted.
REQ-015 On accept, in range: update each byte whose wstrb bit is set; bresp = OKAY (2'b00).
REQ-016 On accept, out of range: no register change; bresp = DECERR (2'b11).
REQ-017 Accept moves the write path to RESP with bvalid=1 the next cycle (write latency 1).
REQ-018 RESP: awready = wready = 0; bvalid held with stable bresp until bready. bvalid && bready returns to IDLE. A new AW/W may be accepted in that same cycle (back-to-back, one write per cycle sustained when bready is high).
REQ-019 Read path: arready = !rvalid || rready (single-entry skid-free pipeline).
REQ-020 On AR accept: rdata = register value, rresp = OKAY, rvalid=1 next cycle (read latency 1). Out of range: rdata = 0, rresp = DECERR.
REQ-021 rvalid, rdata and rresp SHALL hold stable until rready.
REQ-022 Simultaneous read accept and write accept to the same register: read returns the pre-write value.
REQ-023 Byte strobe wstrb = 0 in range: OKAY, no change; wr_pulse still asserts.
REQ-024 wr_pulse/rd_pulse: never asserted for out-of-range accesses; all zero otherwise.
REQ-025 Write and read paths are fully independent; neither stalls the other.
REQ-026 Unused interface outputs (buser, ruser) SHALL be driven 0.

Reset
REQ-027 rst_n=0 at a clock edge: write path to IDLE; bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, wr_pulse=0, rd_pulse=0.
REQ-028 rst_n=0 at a clock edge: every register := RESET_VAL.
REQ-029 During reset, awready = wready = arready = 0.
REQ-030 Reset mid-transaction drops any pending B or R response without completion.
REQ-031 Ready signals SHALL re-assert the first cycle after rst_n rises.

Structure
REQ-032 AXI response codes (OKAY, EXOKAY, SLVERR, DECERR) SHALL come from the shared taxi_axil_pkg package. Add them there if absent.
REQ-033 Single module, no sub-modules. Registers are a flat array of flops (not RAM) so that reg_out is continuously visible.

Verification
REQ-034 Reset, then read reg 3 (addr 0x0C, DATA_W=32) -> rdata=RESET_VAL, rresp=0, rvalid one cycle after AR handshake.
REQ-035 Write 0xDEADBEEF, wstrb=4'b0101, to reg 2 (initially 0) -> bresp=0, wr_pulse[2] one cycle. Read back -> 0x00AD00EF.
REQ-036 AW presented 3 cycles before W -> awready stays 0 until wvalid. Then one accept, one B.
REQ-037 Write to addr REG_CNT*4 -> bresp=2'b11, registers unchanged, wr_pulse=0. Read same addr -> rdata=0, rresp=2'b11.
REQ-038 bready held low 5 cycles, then high -> bvalid stable 5 cycles, no new accept until the release cycle. With rready stuck low, arready=0 after the first read.
REQ-039 Same-cycle write 0x1 and read of reg 0 (holding 0x5) -> read returns 0x5; subsequent read returns 0x1.

Source files
------------

// File: rtl/taxi_axil_pkg.sv
// taxi_axil_pkg: shared AXI4-lite response codes and write-path state encoding
package taxi_axil_pkg;
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axil_resp_t;
  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
endpackage

// File: rtl/taxi_axil_if.sv
// taxi_axil_if: AXI4-lite bundle with separate write and read modports
interface taxi_axil_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int STRB_W = DATA_W/8
);
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              buser;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              ruser;
  logic              rvalid;
  logic              rready;
  modport wr_slv (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, buser, bvalid
  );
  modport rd_slv (
    input  araddr, arprot, arvalid, rready,
    output arready, rdata, rresp, ruser, rvalid
  );
  modport wr_mst (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, buser, bvalid
  );
  modport rd_mst (
    output araddr, arprot, arvalid, rready,
    input  arready, rdata, rresp, ruser, rvalid
  );
endinterface

// File: rtl/taxi_axil_regfile.sv
// taxi_axil_regfile: AXI4-lite flat register file with per-register write/read strobes
module taxi_axil_regfile
  import taxi_axil_pkg::*;
#(
  parameter int          REG_CNT   = 16,
  parameter int          DATA_W    = 32,
  parameter logic [63:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  taxi_axil_if.wr_slv               s_axil_wr,
  taxi_axil_if.rd_slv               s_axil_rd,
  output logic [REG_CNT*DATA_W-1:0] reg_out,
  output logic [REG_CNT-1:0]        wr_pulse,
  output logic [REG_CNT-1:0]        rd_pulse
);
  localparam int STRB_W = DATA_W/8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(REG_CNT);
  logic [DATA_W-1:0]  r_regs [REG_CNT];
  wr_state_t          r_wr_state, w_wr_next;
  logic [1:0]         r_bresp, r_rresp;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_rvalid;
  logic [REG_CNT-1:0] r_wr_pulse;
  logic               w_wr_acc, w_b_done, w_aw_in;
  logic               w_ar_rdy, w_rd_acc, w_ar_in;
  logic [IDX_W-1:0]   w_aw_idx, w_ar_idx;
  logic               w_unused;
  assign w_unused = ^{s_axil_wr.awprot, s_axil_rd.arprot};
  assign w_aw_idx = s_axil_wr.awaddr[OFF_W +: IDX_W];
  assign w_aw_in  = (s_axil_wr.awaddr >> (OFF_W + IDX_W)) == '0;
  assign w_ar_idx = s_axil_rd.araddr[OFF_W +: IDX_W];
  assign w_ar_in  = (s_axil_rd.araddr >> (OFF_W + IDX_W)) == '0;
  always_ff @(posedge clk)
    r_wr_state <= !rst_n ? WR_IDLE : w_wr_next;
  always_comb begin
    w_b_done  = r_wr_state == WR_RESP && s_axil_wr.bready;
    w_wr_acc  = rst_n && (r_wr_state == WR_IDLE || w_b_done) && s_axil_wr.awvalid && s_axil_wr.wvalid;
    w_wr_next = w_wr_acc ? WR_RESP : w_b_done ? WR_IDLE : r_wr_state;
  end
  assign s_axil_wr.awready = w_wr_acc;
  assign s_axil_wr.wready  = w_wr_acc;
  assign s_axil_wr.bvalid  = r_wr_state == WR_RESP;
  assign s_axil_wr.bresp   = r_bresp;
  assign s_axil_wr.buser   = 1'b0;
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_bresp    <= '0;
      r_wr_pulse <= '0;
    end else begin
      if (w_wr_acc) r_bresp <= w_aw_in ? RESP_OKAY : RESP_DECERR;
      r_wr_pulse <= (w_wr_acc && w_aw_in) ? REG_CNT'(1) << w_aw_idx : '0;
    end
  always_ff @(posedge clk)
    if (!rst_n)
      for (int i = 0; i < REG_CNT; i++) r_regs[i] <= RESET_VAL[DATA_W-1:0];
    else if (w_wr_acc && w_aw_in)
      for (int b = 0; b < STRB_W; b++)
        if (s_axil_wr.wstrb[b]) r_regs[w_aw_idx][b*8 +: 8] <= s_axil_wr.wdata[b*8 +: 8];
  assign w_ar_rdy = rst_n && (!r_rvalid || s_axil_rd.rready);
  assign w_rd_acc = w_ar_rdy && s_axil_rd.arvalid;
  assign s_axil_rd.arready = w_ar_rdy;
  assign s_axil_rd.rvalid  = r_rvalid;
  assign s_axil_rd.rdata   = r_rdata;
  assign s_axil_rd.rresp   = r_rresp;
  assign s_axil_rd.ruser   = 1'b0;
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= '0;
    end else if (w_rd_acc) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_ar_in ? r_regs[w_ar_idx] : '0;
      r_rresp  <= w_ar_in ? RESP_OKAY : RESP_DECERR;
    end else if (s_axil_rd.rready) begin
      r_rvalid <= 1'b0;
    end
  assign rd_pulse = (w_rd_acc && w_ar_in) ? REG_CNT'(1) << w_ar_idx : '0;
  assign wr_pulse = r_wr_pulse;
  for (genvar i = 0; i < REG_CNT; i++) begin : g_out
    assign reg_out[i*DATA_W +: DATA_W] = r_regs[i];
  end
endmodule

// File: tb/tb_taxi_axil_regfile.sv
// tb_taxi_axil_regfile: table-driven, directed and randomized checks against a register-array model
module tb_taxi_axil_regfile;
  import taxi_axil_pkg::*;
  localparam int REG_CNT = 16;
  localparam logic [31:0] RV = 32'hA5A5_0F0F;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  taxi_axil_if #(.DATA_W(32), .ADDR_W(16)) axil();
  logic [REG_CNT*32-1:0] reg_out;
  logic [REG_CNT-1:0] wr_pulse, rd_pulse;
  taxi_axil_regfile #(.REG_CNT(REG_CNT), .DATA_W(32), .RESET_VAL(64'(RV))) dut (
    .clk(clk), .rst_n(rst_n), .s_axil_wr(axil), .s_axil_rd(axil),
    .reg_out(reg_out), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
  );
  int n_pass = 0;
  int n_tot = 0;
  logic [31:0] model [REG_CNT];
  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0] s;
    logic [1:0] resp;
    logic [REG_CNT-1:0] wp;
    logic [31:0] rdat;
  } vec_t;
  vec_t tbl [9];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic check_regs(input string name);
    logic [REG_CNT*32-1:0] flat;
    for (int i = 0; i < REG_CNT; i++) flat[i*32 +: 32] = model[i];
    n_tot++;
    if (reg_out === flat) n_pass++;
    else $display("FAIL %s: reg_out %h expected %h", name, reg_out, flat);
  endtask
  function automatic bit in_rng(input logic [15:0] a);
    return int'(a >> 2) < REG_CNT;
  endfunction
  function automatic logic [REG_CNT-1:0] oh(input logic [15:0] a);
    return in_rng(a) ? REG_CNT'(1) << (a >> 2) : '0;
  endfunction
  function automatic logic [31:0] model_read(input logic [15:0] a);
    return in_rng(a) ? model[int'(a >> 2)] : 32'h0;
  endfunction
  task automatic model_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    int idx;
    m = 0;
    for (int b = 0; b < 4; b++) if (s[b]) m |= 32'hFF << (8*b);
    idx = int'(a >> 2);
    if (in_rng(a)) model[idx] = (model[idx] & ~m) | (d & m);
  endtask
  task automatic model_reset();
    for (int i = 0; i < REG_CNT; i++) model[i] = RV;
  endtask
  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [1:0] resp, output logic [REG_CNT-1:0] pulse);
    int n;
    @(posedge clk); #1;
    axil.awaddr = a; axil.wdata = d; axil.wstrb = s; axil.awvalid = 1; axil.wvalid = 1;
    n = 0;
    @(negedge clk);
    while (!axil.awready && n < 20) begin @(negedge clk); n++; end
    check("wr_accept", axil.awready, 1);
    @(posedge clk); #1;
    axil.awvalid = 0; axil.wvalid = 0;
    @(negedge clk);
    check("wr_bvalid", axil.bvalid, 1);
    resp = axil.bresp;
    pulse = wr_pulse;
    axil.bready = 1;
    @(posedge clk); #1;
    axil.bready = 0;
    @(negedge clk);
    check("wr_bvalid_drop", axil.bvalid, 0);
    check("wr_pulse_clear", wr_pulse, 0);
    model_write(a, d, s);
  endtask
  task automatic rd(input logic [15:0] a, output logic [31:0] data, output logic [1:0] resp,
                    output logic [REG_CNT-1:0] pulse);
    int n;
    @(posedge clk); #1;
    axil.araddr = a; axil.arvalid = 1;
    n = 0;
    @(negedge clk);
    while (!axil.arready && n < 20) begin @(negedge clk); n++; end
    check("rd_accept", axil.arready, 1);
    pulse = rd_pulse;
    @(posedge clk); #1;
    axil.arvalid = 0;
    @(negedge clk);
    check("rd_rvalid", axil.rvalid, 1);
    data = axil.rdata;
    resp = axil.rresp;
    axil.rready = 1;
    @(posedge clk); #1;
    axil.rready = 0;
    @(negedge clk);
    check("rd_rvalid_drop", axil.rvalid, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [1:0] resp;
    logic [31:0] data;
    logic [REG_CNT-1:0] pulse;
    logic [31:0] hold;
    tbl[0] = '{16'h0008, 32'h0000_0000, 4'hF, 2'b00, 16'h0004, 32'h0000_0000};
    tbl[1] = '{16'h0008, 32'hDEAD_BEEF, 4'h5, 2'b00, 16'h0004, 32'h00AD_00EF};
    tbl[2] = '{16'h0014, 32'h1122_3344, 4'hF, 2'b00, 16'h0020, 32'h1122_3344};
    tbl[3] = '{16'h0014, 32'hAABB_CCDD, 4'h2, 2'b00, 16'h0020, 32'h1122_CC44};
    tbl[4] = '{16'h0014, 32'hFFFF_FFFF, 4'h0, 2'b00, 16'h0020, 32'h1122_CC44};
    tbl[5] = '{16'h003C, 32'hCAFE_F00D, 4'h8, 2'b00, 16'h8000, 32'hCAA5_0F0F};
    tbl[6] = '{16'h0040, 32'h1234_5678, 4'hF, 2'b11, 16'h0000, 32'h0000_0000};
    tbl[7] = '{16'h8004, 32'h1234_5678, 4'hF, 2'b11, 16'h0000, 32'h0000_0000};
    tbl[8] = '{16'h000B, 32'h0000_00FF, 4'h1, 2'b00, 16'h0004, 32'h00AD_00FF};
    axil.awaddr = 0; axil.awprot = 0; axil.wdata = 0; axil.wstrb = 0;
    axil.araddr = 0; axil.arprot = 0; axil.rready = 0; axil.bready = 0;
    axil.awvalid = 1; axil.wvalid = 1; axil.arvalid = 1;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_awready", axil.awready, 0);
    check("rst_wready", axil.wready, 0);
    check("rst_arready", axil.arready, 0);
    check("rst_bvalid", axil.bvalid, 0);
    @(posedge clk); #1;
    axil.awvalid = 0; axil.wvalid = 0; axil.arvalid = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    check("post_rst_arready", axil.arready, 1);
    check("post_rst_rvalid", axil.rvalid, 0);
    check("post_rst_wr_pulse", wr_pulse, 0);
    check_regs("post_rst_regs");
    rd(16'h000C, data, resp, pulse);
    check("rst_read_data", data, RV);
    check("rst_read_resp", resp, 2'b00);
    check("rst_read_pulse", pulse, oh(16'h000C));
    for (int i = 0; i < 9; i++) begin
      wr(tbl[i].a, tbl[i].d, tbl[i].s, resp, pulse);
      check($sformatf("tbl%0d_bresp", i), resp, tbl[i].resp);
      check($sformatf("tbl%0d_wr_pulse", i), pulse, tbl[i].wp);
      check_regs($sformatf("tbl%0d_regs", i));
      rd(tbl[i].a, data, resp, pulse);
      check($sformatf("tbl%0d_rdata", i), data, tbl[i].rdat);
      check($sformatf("tbl%0d_rresp", i), resp, tbl[i].resp);
      check($sformatf("tbl%0d_rd_pulse", i), pulse, tbl[i].wp);
    end
    @(posedge clk); #1;
    axil.awaddr = 16'h0010; axil.wdata = 32'h0BAD_F00D; axil.wstrb = 4'hF;
    axil.awvalid = 1; axil.wvalid = 0;
    repeat (3) begin
      @(negedge clk);
      check("aw_early_awready", axil.awready, 0);
      check("aw_early_bvalid", axil.bvalid, 0);
      @(posedge clk); #1;
    end
    axil.wvalid = 1;
    @(negedge clk);
    check("aw_early_accept", axil.awready, 1);
    @(posedge clk); #1;
    axil.awvalid = 0; axil.wvalid = 0; axil.bready = 1;
    @(negedge clk);
    check("aw_early_b", axil.bvalid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("aw_early_single_b", axil.bvalid, 0);
    axil.bready = 0;
    model_write(16'h0010, 32'h0BAD_F00D, 4'hF);
    check_regs("aw_early_regs");
    @(posedge clk); #1;
    axil.awaddr = 16'h0018; axil.wdata = 32'h1111_2222; axil.wstrb = 4'hF;
    axil.awvalid = 1; axil.wvalid = 1; axil.bready = 0;
    @(negedge clk);
    check("bp_first_accept", axil.awready, 1);
    @(posedge clk); #1;
    model_write(16'h0018, 32'h1111_2222, 4'hF);
    axil.awaddr = 16'h001C; axil.wdata = 32'h3333_4444;
    repeat (5) begin
      @(negedge clk);
      check("bp_bvalid_held", axil.bvalid, 1);
      check("bp_bresp_held", axil.bresp, 2'b00);
      check("bp_no_accept", axil.awready, 0);
      @(posedge clk); #1;
    end
    axil.bready = 1;
    @(negedge clk);
    check("bp_release_accept", axil.awready, 1);
    @(posedge clk); #1;
    axil.awvalid = 0; axil.wvalid = 0;
    @(negedge clk);
    check("bp_second_b", axil.bvalid, 1);
    check("bp_second_pulse", wr_pulse, oh(16'h001C));
    @(posedge clk); #1;
    axil.bready = 0;
    @(negedge clk);
    check("bp_b_done", axil.bvalid, 0);
    model_write(16'h001C, 32'h3333_4444, 4'hF);
    check_regs("bp_regs");
    @(posedge clk); #1;
    axil.araddr = 16'h0018; axil.arvalid = 1; axil.rready = 0;
    @(negedge clk);
    check("rs_first_accept", axil.arready, 1);
    @(posedge clk); #1;
    axil.araddr = 16'h001C;
    repeat (3) begin
      @(negedge clk);
      check("rs_arready_low", axil.arready, 0);
      check("rs_rvalid_held", axil.rvalid, 1);
      check("rs_rdata_held", axil.rdata, model_read(16'h0018));
      check("rs_rd_pulse_low", rd_pulse, 0);
      @(posedge clk); #1;
    end
    axil.rready = 1;
    @(negedge clk);
    check("rs_release_accept", axil.arready, 1);
    check("rs_release_pulse", rd_pulse, oh(16'h001C));
    @(posedge clk); #1;
    axil.arvalid = 0;
    @(negedge clk);
    check("rs_second_rvalid", axil.rvalid, 1);
    check("rs_second_rdata", axil.rdata, model_read(16'h001C));
    @(posedge clk); #1;
    axil.rready = 0;
    @(negedge clk);
    check("rs_done", axil.rvalid, 0);
    wr(16'h0000, 32'h0000_0005, 4'hF, resp, pulse);
    @(posedge clk); #1;
    axil.awaddr = 16'h0000; axil.wdata = 32'h0000_0001; axil.wstrb = 4'hF;
    axil.awvalid = 1; axil.wvalid = 1; axil.araddr = 16'h0000; axil.arvalid = 1;
    @(negedge clk);
    check("same_cycle_awready", axil.awready, 1);
    check("same_cycle_arready", axil.arready, 1);
    @(posedge clk); #1;
    axil.awvalid = 0; axil.wvalid = 0; axil.arvalid = 0;
    @(negedge clk);
    check("same_cycle_old_data", axil.rdata, 32'h0000_0005);
    check("same_cycle_bvalid", axil.bvalid, 1);
    axil.bready = 1; axil.rready = 1;
    @(posedge clk); #1;
    axil.bready = 0; axil.rready = 0;
    model_write(16'h0000, 32'h0000_0001, 4'hF);
    rd(16'h0000, data, resp, pulse);
    check("same_cycle_new_data", data, 32'h0000_0001);
    @(posedge clk); #1;
    axil.awaddr = 16'h0020; axil.wdata = 32'h7777_7777; axil.wstrb = 4'hF;
    axil.awvalid = 1; axil.wvalid = 1; axil.araddr = 16'h0024; axil.arvalid = 1;
    @(posedge clk); #1;
    axil.awvalid = 0; axil.wvalid = 0; axil.arvalid = 0;
    rst_n = 0;
    @(negedge clk);
    check("mid_rst_pending_b", axil.bvalid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_bvalid", axil.bvalid, 0);
    check("mid_rst_rvalid", axil.rvalid, 0);
    check("mid_rst_rdata", axil.rdata, 0);
    check("mid_rst_arready", axil.arready, 0);
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    @(negedge clk);
    check("mid_rst_ready_back", axil.arready, 1);
    check_regs("mid_rst_regs");
    for (int k = 0; k < 300; k++) begin
      logic [15:0] a;
      logic [31:0] d;
      logic [3:0] s;
      logic [1:0] er;
      logic [REG_CNT-1:0] ep;
      logic [31:0] ed;
      a = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
      d = $urandom;
      s = 4'($urandom);
      er = in_rng(a) ? 2'b00 : 2'b11;
      ep = oh(a);
      if ($urandom_range(0, 1) == 1) begin
        wr(a, d, s, resp, pulse);
        check("rnd_bresp", resp, er);
        check("rnd_wr_pulse", pulse, ep);
        check_regs("rnd_regs");
      end else begin
        ed = model_read(a);
        rd(a, data, resp, pulse);
        check("rnd_rdata", data, ed);
        check("rnd_rresp", resp, er);
        check("rnd_rd_pulse", pulse, ep);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
